// File: rtl/blackbox_sweeper_if.sv
// Bundle between blackbox_sweeper and its driver/observer.
// BLACKBOX_SWEEPER_CHECK_EN adds the expected/mismatch self-check pair.
interface blackbox_sweeper_if;
  logic       start;
  logic       j_in;
  logic       g_out;
  logic       v_out;
  logic       y_out;
  logic       busy;
  logic       done;
  logic [7:0] truth_table;
  // Debug view of the FSM: 0 IDLE, 1 SETTLE, 2 CAPTURE, 3 FINISH.
  logic [1:0] fsm_state;
`ifdef BLACKBOX_SWEEPER_CHECK_EN
  logic [7:0] expected;
  logic       mismatch;

  modport master (
    output start, j_in, expected,
    input  g_out, v_out, y_out, busy, done, truth_table, fsm_state, mismatch
  );

  modport slave (
    input  start, j_in, expected,
    output g_out, v_out, y_out, busy, done, truth_table, fsm_state, mismatch
  );
`else
  modport master (
    output start, j_in,
    input  g_out, v_out, y_out, busy, done, truth_table, fsm_state
  );

  modport slave (
    input  start, j_in,
    output g_out, v_out, y_out, busy, done, truth_table, fsm_state
  );
`endif
endinterface

// File: rtl/blackbox_sweeper.sv
// Walks {g,v,y} through 000..111, holds each combination SETTLE_CYCLES cycles, then samples j.
// Optional macro BLACKBOX_SWEEPER_CHECK_EN compares the captured table against bus.expected.
module blackbox_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic               clk,
  input logic               reset,
  blackbox_sweeper_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    FINISH  = 2'd3
  } state_t;

  // Counter runs 0..SETTLE_CYCLES-1, so 4 bits cover the legal 1..15 range.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [2:0] idx;
  logic [3:0] settle_cnt;
  logic [7:0] tt_q;
  logic [7:0] cap_tt;
  logic       g_q;
  logic       v_q;
  logic       y_q;
  logic       busy_q;
  logic       done_q;

  // Table as it will look once the current index has been captured.
  always_comb begin
    cap_tt      = tt_q;
    cap_tt[idx] = bus.j_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= 3'd0;
      settle_cnt <= 4'd0;
      tt_q       <= 8'd0;
      g_q        <= 1'b0;
      v_q        <= 1'b0;
      y_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state           <= SETTLE;
            idx             <= 3'd0;
            settle_cnt      <= 4'd0;
            tt_q            <= 8'd0;
            {g_q, v_q, y_q} <= 3'd0;
            busy_q          <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= CAPTURE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        CAPTURE: begin
          tt_q <= cap_tt;
          if (idx != 3'd7) begin
            idx             <= idx + 3'd1;
            settle_cnt      <= 4'd0;
            {g_q, v_q, y_q} <= idx + 3'd1;
            state           <= SETTLE;
          end else begin
            // Index stays at 7; the drive lines drop to 0 rather than wrapping.
            {g_q, v_q, y_q} <= 3'd0;
            busy_q          <= 1'b0;
            done_q          <= 1'b1;
            state           <= FINISH;
          end
        end
        FINISH: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef BLACKBOX_SWEEPER_CHECK_EN
  logic mismatch_q;

  // Verdict lands together with done and holds until the next accepted start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mismatch_q <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      mismatch_q <= 1'b0;
    end else if (state == CAPTURE && idx == 3'd7) begin
      mismatch_q <= (cap_tt != bus.expected);
    end
  end

  assign bus.mismatch = mismatch_q;
`endif

  assign bus.g_out       = g_q;
  assign bus.v_out       = v_q;
  assign bus.y_out       = y_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.truth_table = tt_q;
  assign bus.fsm_state   = state;

endmodule

// File: tb/tb_blackbox_sweeper.sv
// Bench for blackbox_sweeper: two instances (SETTLE_CYCLES 2 and 1), each driven by a table-defined blackbox.
// Expected truth tables are queued at start and popped when done is seen.
module tb_blackbox_sweeper;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  blackbox_sweeper_if bus_a ();
  blackbox_sweeper_if bus_b ();

  blackbox_sweeper #(.SETTLE_CYCLES(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  blackbox_sweeper #(.SETTLE_CYCLES(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // Blackbox models: j = model[{g,v,y}].
  logic [7:0] model_a;
  logic [7:0] model_b;
  assign bus_a.j_in = model_a[{bus_a.g_out, bus_a.v_out, bus_a.y_out}];
  assign bus_b.j_in = model_b[{bus_b.g_out, bus_b.v_out, bus_b.y_out}];

  // Observation mux so one set of tasks serves both instances.
  logic       sel;
  logic [2:0] o_gvy;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_tt;
  logic [1:0] o_state;
  logic       o_mm;

  always_comb begin
    o_mm = 1'b0;
    if (sel) begin
      o_gvy   = {bus_b.g_out, bus_b.v_out, bus_b.y_out};
      o_busy  = bus_b.busy;
      o_done  = bus_b.done;
      o_tt    = bus_b.truth_table;
      o_state = bus_b.fsm_state;
`ifdef BLACKBOX_SWEEPER_CHECK_EN
      o_mm    = bus_b.mismatch;
`endif
    end else begin
      o_gvy   = {bus_a.g_out, bus_a.v_out, bus_a.y_out};
      o_busy  = bus_a.busy;
      o_done  = bus_a.done;
      o_tt    = bus_a.truth_table;
      o_state = bus_a.fsm_state;
`ifdef BLACKBOX_SWEEPER_CHECK_EN
      o_mm    = bus_a.mismatch;
`endif
    end
  end

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_start(input bit s, input logic v);
    if (s) bus_b.start = v;
    else   bus_a.start = v;
  endtask

  task automatic set_model(input bit s, input logic [7:0] m, input logic [7:0] exp_cfg);
    if (s) model_b = m;
    else   model_a = m;
`ifdef BLACKBOX_SWEEPER_CHECK_EN
    if (s) bus_b.expected = exp_cfg;
    else   bus_a.expected = exp_cfg;
`else
    if (exp_cfg === 8'hxx) $display("note: unknown expected pattern");
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_gvy"}, 32'(o_gvy), 32'd0);
    check_val({tag, "_busy"}, 32'(o_busy), 32'd0);
    check_val({tag, "_done"}, 32'(o_done), 32'd0);
    check_val({tag, "_tt"}, 32'(o_tt), 32'd0);
    check_val({tag, "_state"}, 32'(o_state), 32'd0);
    check_val({tag, "_mismatch"}, 32'(o_mm), 32'd0);
  endtask

  // One full sweep: per-cycle index/busy checks, then done cycle, table and verdict.
  task automatic run_sweep(input bit s, input logic [7:0] m, input logic [7:0] exp_cfg, input int settle);
    int period;
    int last;
    int k;
    bit seen;
    logic [7:0] exp_tt;
    period = settle + 1;
    last   = 8 * period + 1;
    sel    = s;
    set_model(s, m, exp_cfg);
    @(negedge clk);
    set_start(s, 1'b1);
    exp_q.push_back(m);
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 100) begin
      @(negedge clk);
      k++;
      if (k == 1) set_start(s, 1'b0);
      if (o_done) begin
        seen = 1'b1;
      end else if (k <= 8 * period) begin
        check_val($sformatf("gvy_c%0d", k), 32'(o_gvy), 32'((k - 1) / period));
        check_val($sformatf("busy_c%0d", k), 32'(o_busy), 32'd1);
`ifdef BLACKBOX_SWEEPER_CHECK_EN
        if (k == 1) check_val("mismatch_cleared_on_start", 32'(o_mm), 32'd0);
`endif
      end
    end
    check_val("done_cycle", 32'(k), 32'(last));
    exp_tt = exp_q.pop_front();
    check_val("truth_table", 32'(o_tt), 32'(exp_tt));
    check_val("finish_gvy", 32'(o_gvy), 32'd0);
    check_val("finish_busy", 32'(o_busy), 32'd0);
    check_val("finish_state", 32'(o_state), 32'd3);
`ifdef BLACKBOX_SWEEPER_CHECK_EN
    check_val("mismatch_finish", 32'(o_mm), 32'(exp_tt != exp_cfg));
`endif
    @(negedge clk);
    check_val("done_one_cycle", 32'(o_done), 32'd0);
    check_val("idle_state", 32'(o_state), 32'd0);
    repeat (3) @(negedge clk);
    check_val("tt_held", 32'(o_tt), 32'(exp_tt));
`ifdef BLACKBOX_SWEEPER_CHECK_EN
    check_val("mismatch_held", 32'(o_mm), 32'(exp_tt != exp_cfg));
`endif
  endtask

  initial begin
    int n_done;
    int c1;
    int c2;
    logic [7:0] m;
    logic [7:0] exp_tt;

    reset       = 1'b0;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    sel         = 1'b0;
    set_model(1'b0, 8'h00, 8'h00);
    set_model(1'b1, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    sel = 1'b0;
    check_idle_outputs("reset_a");
    sel = 1'b1;
    check_idle_outputs("reset_b");
    reset = 1'b1;

    // start low in IDLE: nothing moves.
    sel = 1'b0;
    repeat (4) @(negedge clk);
    check_idle_outputs("idle_no_start");

    // j = g|y, default settle.
    run_sweep(1'b0, 8'hFA, 8'hFA, 2);
    // j = g&v&y, settle 1.
    run_sweep(1'b1, 8'h80, 8'h80, 1);

    for (int i = 0; i < 3; i++) begin
      m = 8'($urandom_range(0, 255));
      run_sweep(1'b0, m, m, 2);
    end
    m = 8'($urandom_range(0, 255));
    run_sweep(1'b1, m, m, 1);

    // Wrong expected pattern, then a clean sweep to see the verdict clear.
    run_sweep(1'b0, 8'hFA, 8'hFB, 2);
    run_sweep(1'b0, 8'hFA, 8'hFA, 2);

    // start held high for 40 cycles: back-to-back sweeps, one done per 26 cycles.
    sel = 1'b0;
    m   = 8'($urandom_range(0, 255));
    set_model(1'b0, m, m);
    @(negedge clk);
    bus_a.start = 1'b1;
    exp_q.push_back(m);
    exp_q.push_back(m);
    n_done = 0;
    c1     = 0;
    c2     = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 40) bus_a.start = 1'b0;
      if (k == 13) check_val("hold_no_restart_gvy", 32'(o_gvy), 32'd4);
      if (k == 26) check_val("hold_idle_gap_busy", 32'(o_busy), 32'd0);
      if (k == 27) check_val("hold_second_busy", 32'(o_busy), 32'd1);
      if (o_done) begin
        n_done++;
        if (n_done == 1) c1 = k;
        if (n_done == 2) c2 = k;
        if (exp_q.size() > 0) begin
          exp_tt = exp_q.pop_front();
          check_val("hold_truth_table", 32'(o_tt), 32'(exp_tt));
        end
      end
    end
    check_val("hold_done_count", 32'(n_done), 32'd2);
    check_val("hold_done1_cycle", 32'(c1), 32'd25);
    check_val("hold_done2_cycle", 32'(c2), 32'd51);
    exp_q.delete();

    // Reset at cycle 10 of a sweep aborts it without a done pulse.
    set_model(1'b0, 8'hFA, 8'hFB);
    @(negedge clk);
    bus_a.start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) bus_a.start = 1'b0;
    end
    check_val("pre_reset_busy", 32'(o_busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    reset  = 1'b1;
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_done) n_done++;
    end
    check_val("no_done_after_abort", 32'(n_done), 32'd0);
    check_val("abort_state_idle", 32'(o_state), 32'd0);
    run_sweep(1'b0, 8'hFA, 8'hFA, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/blackbox_sweeper.md
BLACKBOX_SWEEPER -- requirements
Module: blackbox_sweeper

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, SHALL set the cycles each input combination is held before j is sampled; legal range 1..15.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  sweep request, sampled only in IDLE.
REQ-005 j_in  input  1  blackbox j output under test.
REQ-006 g_out  output  1  drives blackbox g input; equals bit 2 of combination index.
REQ-007 v_out  output  1  drives blackbox v input; equals bit 1 of combination index.
REQ-008 y_out  output  1  drives blackbox y input; equals bit 0 of combination index.
REQ-009 busy  output  1  high while a sweep is in SETTLE or CAPTURE.
REQ-010 done  output  1  one-cycle pulse marking sweep completion.
REQ-011 truth_table  output  8  captured truth table; bit n = j_in observed for index n = {g,v,y}.

Function
REQ-012 FSM states SHALL be IDLE, SETTLE, CAPTURE, FINISH, and no others.
REQ-013 IDLE: g/v/y_out = 0, busy = 0, done = 0; start=1 at an edge SHALL move to SETTLE, clear index to 0, clear settle counter, clear truth_table to 0.
REQ-014 start=0 in IDLE SHALL leave state and truth_table unchanged.
REQ-015 SETTLE: g/v/y_out SHALL equal current index; state SHALL remain SETTLE for exactly SETTLE_CYCLES cycles, then move to CAPTURE.
REQ-016 CAPTURE: g/v/y_out unchanged; at the closing edge truth_table[index] SHALL load j_in.
REQ-017 CAPTURE with index < 7 SHALL increment index, clear settle counter, return to SETTLE.
REQ-018 CAPTURE with index = 7 SHALL go to FINISH; index SHALL NOT wrap to 0 visibly on g/v/y_out (outputs go to 0 in FINISH).
REQ-019 FINISH: done = 1, busy = 0, g/v/y_out = 0, for exactly one cycle, then IDLE unconditionally.
REQ-020 start asserted in SETTLE, CAPTURE, or FINISH SHALL be ignored (no restart, no queuing).
REQ-021 Latency: with start accepted at edge 0, done SHALL be high in cycle 8*(SETTLE_CYCLES+1)+1 (cycle 25 at default).
REQ-022 truth_table SHALL hold its value from FINISH until the next accepted start.
REQ-023 Settle counter SHALL be 4 bits and SHALL NOT overflow for any legal SETTLE_CYCLES.

Reset
REQ-024 reset=0 at an edge SHALL force IDLE, index=0, settle counter=0, truth_table=0, g/v/y_out=0, busy=0, done=0.
REQ-025 reset=0 mid-sweep SHALL abort the sweep with no done pulse; reset SHALL take priority over start.

Configuration
REQ-026 Macro BLACKBOX_SWEEPER_CHECK_EN SHALL, when defined, add ports expected (input, 8) and mismatch (output, 1).
REQ-027 With the macro: mismatch SHALL be set in the FINISH cycle iff truth_table != expected, held until the next accepted start or reset, then cleared to 0.
REQ-028 Without the macro: expected and mismatch SHALL not exist; all other behaviour identical.

Verification
REQ-029 Model j = g|y, default params, pulse start -> done in cycle 25, truth_table = 8'hFA, g/v/y_out stepped 000..111 each held 3 cycles.
REQ-030 Model j = g&v&y, SETTLE_CYCLES=1 -> done in cycle 17, truth_table = 8'h80.
REQ-031 Hold start=1 for 40 cycles -> exactly one done pulse per 26-cycle period (sweep back-to-back, second start accepted only in IDLE); no restart mid-sweep.
REQ-032 reset=0 at cycle 10 of a sweep -> next cycle all outputs 0, state IDLE, no done; fresh start then completes normally.
REQ-033 With BLACKBOX_SWEEPER_CHECK_EN, model j = g|y, expected = 8'hFA -> mismatch=0; expected = 8'hFB -> mismatch=1 from FINISH until next start.
